resp_memoria_dados: RTL and testbench
=====================================

Name: resp_memoria_dados

Overview:
- Data-memory responder for the RISC-V core's load/store initiator.
- Accepts one lw/sw request at a time over a valid/ready handshake and performs the access after a programmable number of wait states.
- Returns a read-data or write-ack response over a second valid/ready handshake.
- Backing store: DEPTH x 64-bit doublewords, addressed by byte address bits [ADDR_LSB+IDX_W-1:ADDR_LSB].

Parameters:
- DEPTH, 32, number of 64-bit words; power of two; IDX_W = log2(DEPTH).
- LATENCY, 1, wait-state cycles between request acceptance and access; range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store (sw), 0 = load (lw).
- req_addr  in  64  byte address (ULA output).
- req_wdata  in  64  store data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator consumes response.
- rsp_rdata  out  64  load data; 0 for store responses.
- rsp_err  out  1  misaligned access flag; constant 0 unless MISALIGN_CHECK_EN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - All DEPTH words cleared to 0.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready at edge E0: capture we, index=req_addr[ADDR_LSB+IDX_W-1:ADDR_LSB], wdata and addr[2:0]; load counter=LATENCY; go to WAIT.
  - WAIT: req_ready=0. If counter!=0, decrement it. If counter==0 at an edge: perform the access (store writes mem[index]; load latches mem[index] into rsp_rdata), set rsp_valid=1, go to RESP.
  - RESP: rsp_valid=1, outputs held stable. On rsp_ready at an edge: rsp_valid=0, rsp_rdata=0, rsp_err=0, go to IDLE.
- Latency: rsp_valid rises at edge E0+LATENCY+1; with rsp_ready tied high, throughput is one request per LATENCY+3 cycles.
- No request is accepted in the same cycle a response retires, because req_ready=0 in RESP.
- Address wrap: bits above ADDR_LSB+IDX_W-1 are ignored, so 0x100 aliases 0x000 for DEPTH=32.
- Stores return rsp_rdata=0; the written value is readable by the next load.
- req_addr/req_wdata changes after acceptance have no effect (captured values are used).
- Reset during WAIT: the pending store is discarded (not committed). Reset during RESP: the response is lost and memory keeps the committed write only until the reset clears it.
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined: a captured addr[2:0]!=0 gives rsp_err=1 in RESP, no memory write, rsp_rdata=0; the latency is unchanged.
- Undefined: addr[2:0] is ignored, rsp_err is tied 0, and misaligned addresses access the containing doubleword.

Decomposition:
- Shared package (core-wide) holds:
  - state enum {IDLE, WAIT, RESP};
  - ADDR_LSB=3;
  - default DEPTH=32;
  - XLEN=64;
  - lw/sw opcode constants (0000011 / 0100011), shared with the instruction decoder.
- One sub-module: banco_palavras_mem — a DEPTH x 64 array with synchronous write, registered read and asynchronous clear, instantiated once. The FSM and handshake live in the top module.

Test Plan:
- Store/load, LATENCY=1: sw addr=0x10 wdata=0xAB → rsp_valid at E0+2, rsp_rdata=0. Then lw addr=0x10 → rsp_rdata=0xAB, rsp_err=0.
- Latency sweep LATENCY=0 and LATENCY=3: a single lw is answered at E0+1 and E0+4 respectively. req_ready=0 from E0+1 until the retire edge.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid and rsp_rdata stable, req_valid ignored. Raise rsp_ready → IDLE next edge, new request accepted the following edge.
- Wrap: sw addr=0x108 wdata=0x55, then lw addr=0x008 → rsp_rdata=0x55.
- Reset mid-WAIT (LATENCY=3): sw addr=0x20 wdata=0x77, pulse rst_n low at E0+1 → no response, outputs at reset values; a following lw addr=0x20 returns 0.
- MISALIGN_CHECK_EN defined: sw addr=0x13 wdata=0x99 → rsp_err=1. A following lw addr=0x10 returns prior contents (0); with the macro undefined, the same lw returns 0x99.

Source files
------------

// File: rtl/resp_memoria_dados_pkg.sv
// Core-wide shared definitions for the data-memory responder and its
// neighbours (instruction decoder, load/store initiator).
// Optional feature macro: MISALIGN_CHECK_EN (see resp_memoria_dados.sv).
package resp_memoria_dados_pkg;

  localparam int XLEN          = 64;
  localparam int ADDR_LSB      = 3;   // byte offset bits inside a doubleword
  localparam int DEFAULT_DEPTH = 32;

  // Major opcodes for loads and stores, shared with the instruction decoder.
  localparam logic [6:0] OPCODE_LW = 7'b0000011;
  localparam logic [6:0] OPCODE_SW = 7'b0100011;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/resp_memoria_dados_if.sv
// Request/response handshake bundle between the load/store initiator
// (master) and the data-memory responder (slave).
interface resp_memoria_dados_if;
  import resp_memoria_dados_pkg::*;

  // Request channel
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  // Response channel
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/resp_memoria_dados_banco_palavras_mem.sv
// banco_palavras_mem: DEPTH x WIDTH word bank with synchronous write,
// registered read port and asynchronous clear of every word.
// The read register doubles as the response data register of the
// responder, so it also has a synchronous clear used when a response retires.
module banco_palavras_mem #(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             rd_clr,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Word array: cleared on reset, one word written per enabled edge.
  // NOTE: resetting every word forces flops instead of a RAM macro; it is
  // kept because reset must leave the whole store reading as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[idx] <= wdata;
    end
  end

  // Registered read port; holds its value until explicitly cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end else if (rd_clr) begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/resp_memoria_dados.sv
// resp_memoria_dados: data-memory responder for the core's load/store unit.
// One lw/sw at a time: request handshake in IDLE, LATENCY wait states,
// then the access and a response held until the initiator consumes it.
// Optional feature: define MISALIGN_CHECK_EN to flag accesses whose byte
// address is not doubleword aligned (rsp_err=1, no write, rdata=0).
// Without it, misaligned addresses silently hit the containing doubleword.
module resp_memoria_dados
  import resp_memoria_dados_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  resp_memoria_dados_if.slave bus
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

  state_t           state;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [3:0]       wait_cnt;
  logic             we_q;
  logic [IDX_W-1:0] idx_q;
  logic [XLEN-1:0]  wdata_q;
  logic             misaligned;

  logic             access_now;
  logic             mem_wr_en;
  logic             mem_rd_en;
  logic             mem_rd_clr;
  logic [XLEN-1:0]  mem_rdata;

`ifdef MISALIGN_CHECK_EN
  logic [2:0]       off_q;
  logic             rsp_err_q;
  logic             unused_addr;

  assign misaligned  = (off_q != 3'b000);
  assign unused_addr = ^bus.req_addr[XLEN-1:ADDR_LSB+IDX_W];
`else
  logic             unused_addr;

  assign misaligned  = 1'b0;
  assign unused_addr = ^{bus.req_addr[XLEN-1:ADDR_LSB+IDX_W],
                         bus.req_addr[ADDR_LSB-1:0]};
`endif

  // Handshake FSM: capture in IDLE, count wait states, hold the response.
  // NOTE: all state here updates with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      wait_cnt    <= '0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
`ifdef MISALIGN_CHECK_EN
      off_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            idx_q       <= bus.req_addr[ADDR_LSB+IDX_W-1:ADDR_LSB];
            wdata_q     <= bus.req_wdata;
`ifdef MISALIGN_CHECK_EN
            off_q       <= bus.req_addr[2:0];
`endif
            wait_cnt    <= LAT_LOAD;
            req_ready_q <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            // The memory access itself happens on this same edge.
            rsp_valid_q <= 1'b1;
`ifdef MISALIGN_CHECK_EN
            rsp_err_q   <= misaligned;
`endif
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Word-bank strobes: access on the last wait edge, clear on retire.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    access_now = 1'b0;
    mem_wr_en  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_rd_clr = 1'b0;
    if (state == WAIT && wait_cnt == 4'd0) begin
      access_now = 1'b1;
    end
    if (access_now && !misaligned) begin
      if (we_q) begin
        mem_wr_en = 1'b1;
      end else begin
        mem_rd_en = 1'b1;
      end
    end
    if (state == RESP && bus.rsp_ready) begin
      mem_rd_clr = 1'b1;
    end
  end

  banco_palavras_mem #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .WIDTH (XLEN)
  ) u_banco (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (mem_wr_en),
    .rd_en  (mem_rd_en),
    .rd_clr (mem_rd_clr),
    .idx    (idx_q),
    .wdata  (wdata_q),
    .rdata  (mem_rdata)
  );

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = mem_rdata;
`ifdef MISALIGN_CHECK_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_resp_memoria_dados.sv
// Testbench for resp_memoria_dados: three instances (LATENCY 1, 0, 3)
// driven through per-instance signal arrays, a directed vector table,
// hand-written corner sequences and a randomized run against an array model.
module tb_resp_memoria_dados;
  import resp_memoria_dados_pkg::*;

  localparam int N_DUT = 3;
  localparam int DEPTH = 32;
  localparam int BOUND = 40;
  localparam int LAT [N_DUT] = '{1, 0, 3};

`ifdef MISALIGN_CHECK_EN
  localparam logic        MIS_ERR  = 1'b1;
  localparam logic [63:0] MIS_LOAD = 64'h0;
`else
  localparam logic        MIS_ERR  = 1'b0;
  localparam logic [63:0] MIS_LOAD = 64'h99;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a     [N_DUT];
  logic        req_valid_a [N_DUT];
  logic        req_we_a    [N_DUT];
  logic [63:0] req_addr_a  [N_DUT];
  logic [63:0] req_wdata_a [N_DUT];
  logic        rsp_ready_a [N_DUT];
  logic        req_ready_a [N_DUT];
  logic        rsp_valid_a [N_DUT];
  logic [63:0] rsp_rdata_a [N_DUT];
  logic        rsp_err_a   [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    resp_memoria_dados_if bus ();
    assign bus.req_valid = req_valid_a[g];
    assign bus.req_we    = req_we_a[g];
    assign bus.req_addr  = req_addr_a[g];
    assign bus.req_wdata = req_wdata_a[g];
    assign bus.rsp_ready = rsp_ready_a[g];
    assign req_ready_a[g] = bus.req_ready;
    assign rsp_valid_a[g] = bus.rsp_valid;
    assign rsp_rdata_a[g] = bus.rsp_rdata;
    assign rsp_err_a[g]   = bus.rsp_err;

    resp_memoria_dados #(
      .DEPTH   (DEPTH),
      .LATENCY (LAT[g])
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n_a[g]),
      .bus   (bus)
    );
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: one plain array of doublewords per instance.
  logic [63:0] model_mem [N_DUT][DEPTH];

  task automatic model_clear(input int s);
    for (int i = 0; i < DEPTH; i++) model_mem[s][i] = 64'h0;
  endtask

  task automatic model_access(input int s, input logic we, input logic [63:0] addr,
                              input logic [63:0] wdata,
                              output logic [63:0] exp_rdata, output logic exp_err);
    int idx;
    idx       = int'((addr / 64'd8) % 64'(DEPTH));
    exp_rdata = 64'h0;
    exp_err   = 1'b0;
`ifdef MISALIGN_CHECK_EN
    exp_err = (addr % 64'd8) != 64'd0;
`endif
    if (!exp_err) begin
      if (we) model_mem[s][idx] = wdata;
      else    exp_rdata = model_mem[s][idx];
    end
  endtask

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    logic        ready_low;
    logic        stable;
    logic        retired_ok;
  } txn_res_t;

  // Counts edges from acceptance until rsp_valid is seen (bounded);
  // also records whether req_ready stayed low the whole time.
  task automatic wait_rsp(input int s, output int lat, output logic ready_low);
    lat       = 0;
    ready_low = 1'b1;
    while (1) begin
      if (req_ready_a[s]) ready_low = 1'b0;
      if (rsp_valid_a[s] || lat >= BOUND) break;
      @(negedge clk);
      lat++;
    end
  endtask

  // One full transaction, called at a negedge. After acceptance the request
  // bus keeps req_valid high with scrambled contents until retirement.
  task automatic run_txn(input int s, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input int hold, output txn_res_t r);
    int   n;
    int   lat;
    logic rl;
    n = 0;
    while (!req_ready_a[s] && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    req_valid_a[s] = 1'b1;
    req_we_a[s]    = we;
    req_addr_a[s]  = addr;
    req_wdata_a[s] = wdata;
    @(negedge clk);
    req_we_a[s]    = ~we;
    req_addr_a[s]  = {$urandom, $urandom};
    req_wdata_a[s] = {$urandom, $urandom};
    wait_rsp(s, lat, rl);
    r.lat       = lat;
    r.ready_low = rl;
    r.rdata     = rsp_rdata_a[s];
    r.err       = rsp_err_a[s];
    r.stable    = rsp_valid_a[s];
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid_a[s] || req_ready_a[s] || rsp_rdata_a[s] !== r.rdata ||
          rsp_err_a[s] !== r.err) r.stable = 1'b0;
    end
    rsp_ready_a[s] = 1'b1;
    @(negedge clk);
    rsp_ready_a[s] = 1'b0;
    req_valid_a[s] = 1'b0;
    r.retired_ok = !rsp_valid_a[s] && req_ready_a[s] &&
                   (rsp_rdata_a[s] === 64'h0) && (rsp_err_a[s] === 1'b0);
  endtask

  task automatic do_check_txn(input string tag, input int s, input logic we,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input int hold, input logic [63:0] exp_rdata,
                              input logic exp_err);
    txn_res_t r;
    run_txn(s, we, addr, wdata, hold, r);
    check({tag, " rdata"}, r.rdata, exp_rdata);
    check({tag, " err"}, 64'(r.err), 64'(exp_err));
    check({tag, " latency"}, 64'(r.lat), 64'(LAT[s] + 1));
    check({tag, " req_ready low while busy"}, 64'(r.ready_low), 64'h1);
    check({tag, " response stable"}, 64'(r.stable), 64'h1);
    check({tag, " retire"}, 64'(r.retired_ok), 64'h1);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] er;
    logic        ee;

    for (int s = 0; s < N_DUT; s++) begin
      rst_n_a[s]     = 1'b0;
      req_valid_a[s] = 1'b0;
      req_we_a[s]    = 1'b0;
      req_addr_a[s]  = 64'h0;
      req_wdata_a[s] = 64'h0;
      rsp_ready_a[s] = 1'b0;
      model_clear(s);
    end

    // Reset state
    #12;
    for (int s = 0; s < N_DUT; s++) begin
      check($sformatf("reset req_ready[%0d]", s), 64'(req_ready_a[s]), 64'h1);
      check($sformatf("reset rsp_valid[%0d]", s), 64'(rsp_valid_a[s]), 64'h0);
      check($sformatf("reset rsp_rdata[%0d]", s), rsp_rdata_a[s], 64'h0);
      check($sformatf("reset rsp_err[%0d]", s), 64'(rsp_err_a[s]), 64'h0);
    end
    @(negedge clk);
    for (int s = 0; s < N_DUT; s++) rst_n_a[s] = 1'b1;
    @(negedge clk);

    // Directed vectors on the LATENCY=1 instance
    tbl[0] = '{"sw misaligned 0x13", 1'b1, 64'h13,  64'h99, 64'h0,   MIS_ERR};
    tbl[1] = '{"lw 0x10 after 0x13", 1'b0, 64'h10,  64'h0,  MIS_LOAD, 1'b0};
    tbl[2] = '{"sw 0x10 AB",         1'b1, 64'h10,  64'hAB, 64'h0,   1'b0};
    tbl[3] = '{"lw 0x10",            1'b0, 64'h10,  64'h0,  64'hAB,  1'b0};
    tbl[4] = '{"sw wrap 0x108",      1'b1, 64'h108, 64'h55, 64'h0,   1'b0};
    tbl[5] = '{"lw wrap 0x008",      1'b0, 64'h008, 64'h0,  64'h55,  1'b0};
    tbl[6] = '{"lw alias 0x100",     1'b0, 64'h100, 64'h0,  64'h0,   1'b0};
    tbl[7] = '{"lw top word 0xF8",   1'b0, 64'hF8,  64'h0,  64'h0,   1'b0};
    for (int i = 0; i < 8; i++) begin
      model_access(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, er, ee);
      do_check_txn(tbl[i].name, 0, tbl[i].we, tbl[i].addr, tbl[i].wdata, 0,
                   tbl[i].exp_rdata, tbl[i].exp_err);
    end

    // Latency sweep: single loads on the LATENCY=0 and LATENCY=3 instances
    do_check_txn("lat0 lw", 1, 1'b0, 64'h40, 64'h0, 0, 64'h0, 1'b0);
    do_check_txn("lat3 lw", 2, 1'b0, 64'h40, 64'h0, 0, 64'h0, 1'b0);

    // Backpressure: response held 5 cycles while a new request waits
    begin
      int          lat;
      logic        rl;
      logic        held_ok;
      req_valid_a[0] = 1'b1;
      req_we_a[0]    = 1'b0;
      req_addr_a[0]  = 64'h10;
      @(negedge clk);
      req_addr_a[0]  = 64'h008;
      wait_rsp(0, lat, rl);
      check("bp first latency", 64'(lat), 64'h2);
      held_ok = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (!rsp_valid_a[0] || req_ready_a[0] || rsp_rdata_a[0] !== 64'hAB) held_ok = 1'b0;
      end
      check("bp held stable", 64'(held_ok), 64'h1);
      rsp_ready_a[0] = 1'b1;
      @(negedge clk);
      rsp_ready_a[0] = 1'b0;
      check("bp idle after retire", 64'(req_ready_a[0]), 64'h1);
      check("bp rsp_valid after retire", 64'(rsp_valid_a[0]), 64'h0);
      @(negedge clk);
      req_valid_a[0] = 1'b0;
      check("bp second accepted", 64'(req_ready_a[0]), 64'h0);
      wait_rsp(0, lat, rl);
      check("bp second latency", 64'(lat), 64'h2);
      check("bp second rdata", rsp_rdata_a[0], 64'h55);
      rsp_ready_a[0] = 1'b1;
      @(negedge clk);
      rsp_ready_a[0] = 1'b0;
    end

    // Reset during WAIT discards the pending store (LATENCY=3 instance)
    begin
      logic seen;
      req_valid_a[2] = 1'b1;
      req_we_a[2]    = 1'b1;
      req_addr_a[2]  = 64'h20;
      req_wdata_a[2] = 64'h77;
      @(negedge clk);
      req_valid_a[2] = 1'b0;
      @(posedge clk);
      #1 rst_n_a[2] = 1'b0;
      #2;
      check("rst-wait req_ready", 64'(req_ready_a[2]), 64'h1);
      check("rst-wait rsp_valid", 64'(rsp_valid_a[2]), 64'h0);
      check("rst-wait rsp_rdata", rsp_rdata_a[2], 64'h0);
      check("rst-wait rsp_err", 64'(rsp_err_a[2]), 64'h0);
      @(negedge clk);
      rst_n_a[2] = 1'b1;
      model_clear(2);
      seen = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (rsp_valid_a[2]) seen = 1'b1;
      end
      check("rst-wait no response", 64'(seen), 64'h0);
      do_check_txn("rst-wait lw 0x20", 2, 1'b0, 64'h20, 64'h0, 0, 64'h0, 1'b0);
    end

    // Randomized traffic against the model
    for (int t = 0; t < 150; t++) begin
      int          s;
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      s     = int'($urandom_range(0, N_DUT - 1));
      we    = 1'($urandom_range(0, 1));
      addr  = 64'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) addr[63:32] = $urandom;
      if ($urandom_range(0, 3) != 0) addr[2:0] = 3'b000;
      wdata = {$urandom, $urandom};
      model_access(s, we, addr, wdata, er, ee);
      do_check_txn($sformatf("rand%0d dut%0d", t, s), s, we, addr, wdata,
                   int'($urandom_range(0, 3)), er, ee);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
